// File: rtl/vga_timing_gen_if.sv
// vga_timing_gen_if: raster timing bundle from the timing generator to the colour stage.
// Optional macro VGA_TEST_PATTERN_EN adds the tp_red/tp_green/tp_blue test-pattern channels.
interface vga_timing_gen_if;
    logic       pix_tick;
    logic       hsync;
    logic       vsync;
    logic       video_on;
    logic [9:0] pix_x;
    logic [9:0] pix_y;
    logic       frame_start;
`ifdef VGA_TEST_PATTERN_EN
    logic [3:0] tp_red;
    logic [3:0] tp_green;
    logic [3:0] tp_blue;
`endif

`ifdef VGA_TEST_PATTERN_EN
    // Timing generator side: drives every signal.
    modport master (
        output pix_tick, hsync, vsync, video_on, pix_x, pix_y, frame_start,
        output tp_red, tp_green, tp_blue
    );
    // Colour stage side: consumes every signal.
    modport slave (
        input pix_tick, hsync, vsync, video_on, pix_x, pix_y, frame_start,
        input tp_red, tp_green, tp_blue
    );
`else
    // Timing generator side: drives every signal.
    modport master (
        output pix_tick, hsync, vsync, video_on, pix_x, pix_y, frame_start
    );
    // Colour stage side: consumes every signal.
    modport slave (
        input pix_tick, hsync, vsync, video_on, pix_x, pix_y, frame_start
    );
`endif
endinterface

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: VGA raster timing (default 640x480@60 from a 100 MHz clock).
// A clock-enable divider produces the pixel rate, so everything runs on clock_i.
// Optional macro VGA_TEST_PATTERN_EN adds an 8-bar colour pattern on tp_red/tp_green/tp_blue.
module vga_timing_gen #(
    parameter int CLK_DIV  = 4,
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter bit SYNC_POL = 1'b0
) (
    input  logic             clock_i,
    input  logic             res_i,
    vga_timing_gen_if.master vga_o
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_ACT    = 10'(H_ACTIVE);
    localparam logic [9:0] V_ACT    = 10'(V_ACTIVE);
    localparam logic [9:0] HS_FIRST = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] HS_LAST  = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [9:0] VS_FIRST = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] VS_LAST  = 10'(V_ACTIVE + V_FP + V_SYNC - 1);

    // Counter state.
    logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
    logic [9:0]       h_cnt_q, h_cnt_d;
    logic [9:0]       v_cnt_q, v_cnt_d;
    // Set on every reset edge; marks the first edge after release, which
    // starts pixel (0,0) and must not advance the divider or the raster.
    logic             start_q;
    logic             tick;
    logic             h_wrap;
    logic             v_wrap;

    // Registered outputs and their next-state values.
    logic pix_tick_q, pix_tick_d;
    logic hsync_q, hsync_d;
    logic vsync_q, vsync_d;
    logic video_on_q, video_on_d;
    logic frame_start_q, frame_start_d;

    // Divider, pixel tick and raster counter next-state.
    always_comb begin
        tick      = !start_q && (div_cnt_q == DIV_LAST);
        h_wrap    = (h_cnt_q == H_LAST);
        v_wrap    = (v_cnt_q == V_LAST);
        div_cnt_d = div_cnt_q;
        h_cnt_d   = h_cnt_q;
        v_cnt_d   = v_cnt_q;

        if (start_q || (div_cnt_q == DIV_LAST)) begin
            div_cnt_d = '0;
        end else begin
            div_cnt_d = div_cnt_q + 1'b1;
        end

        if (tick) begin
            if (h_wrap) begin
                h_cnt_d = '0;
                v_cnt_d = v_wrap ? 10'd0 : (v_cnt_q + 10'd1);
            end else begin
                h_cnt_d = h_cnt_q + 10'd1;
            end
        end
    end

    // Output next-state, derived from the next counter values so that the
    // flags and coordinates always describe the same pixel.
    always_comb begin
        pix_tick_d    = tick;
        video_on_d    = (h_cnt_d < H_ACT) && (v_cnt_d < V_ACT);
        hsync_d       = ((h_cnt_d >= HS_FIRST) && (h_cnt_d <= HS_LAST)) ? SYNC_POL : ~SYNC_POL;
        vsync_d       = ((v_cnt_d >= VS_FIRST) && (v_cnt_d <= VS_LAST)) ? SYNC_POL : ~SYNC_POL;
        frame_start_d = start_q || (tick && h_wrap && v_wrap);
    end

    // Counter and start-flag registers; reset returns the raster to (0,0).
    always_ff @(posedge clock_i) begin
        if (!res_i) begin
            div_cnt_q <= '0;
            h_cnt_q   <= '0;
            v_cnt_q   <= '0;
            start_q   <= 1'b1;
        end else begin
            div_cnt_q <= div_cnt_d;
            h_cnt_q   <= h_cnt_d;
            v_cnt_q   <= v_cnt_d;
            start_q   <= 1'b0;
        end
    end

    // Output registers; syncs rest at their inactive level in reset.
    always_ff @(posedge clock_i) begin
        if (!res_i) begin
            pix_tick_q    <= 1'b0;
            hsync_q       <= ~SYNC_POL;
            vsync_q       <= ~SYNC_POL;
            video_on_q    <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            pix_tick_q    <= pix_tick_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            video_on_q    <= video_on_d;
            frame_start_q <= frame_start_d;
        end
    end

    // The coordinates are the counters themselves, reported in blanking too.
    assign vga_o.pix_tick    = pix_tick_q;
    assign vga_o.hsync       = hsync_q;
    assign vga_o.vsync       = vsync_q;
    assign vga_o.video_on    = video_on_q;
    assign vga_o.pix_x       = h_cnt_q;
    assign vga_o.pix_y       = v_cnt_q;
    assign vga_o.frame_start = frame_start_q;

`ifdef VGA_TEST_PATTERN_EN
    localparam int BAR_W = H_ACTIVE / 8;
    // Bars lit per channel, bit n = bar n (left to right):
    // white, yellow, cyan, green, magenta, red, blue, black.
    localparam logic [7:0] RED_BARS   = 8'b0011_0011;
    localparam logic [7:0] GREEN_BARS = 8'b0000_1111;
    localparam logic [7:0] BLUE_BARS  = 8'b0101_0101;

    // bar_ge[n]: next column is at or right of the left edge of bar n.
    logic [8:0] bar_ge;
    logic [7:0] bar_sel;
    logic [3:0] tp_red_q, tp_red_d;
    logic [3:0] tp_green_q, tp_green_d;
    logic [3:0] tp_blue_q, tp_blue_d;

    assign bar_ge[0] = 1'b1;
    assign bar_ge[8] = 1'b0;

    genvar gi;
    generate
        for (gi = 1; gi < 8; gi++) begin : g_bar_edge
            assign bar_ge[gi] = (h_cnt_d >= 10'(gi * BAR_W));
        end
        for (gi = 0; gi < 8; gi++) begin : g_bar_sel
            assign bar_sel[gi] = bar_ge[gi] & ~bar_ge[gi + 1];
        end
    endgenerate

    // Colour lookup for the bar under the next pixel, blanked outside video.
    always_comb begin
        tp_red_d   = (video_on_d && |(bar_sel & RED_BARS))   ? 4'hF : 4'h0;
        tp_green_d = (video_on_d && |(bar_sel & GREEN_BARS)) ? 4'hF : 4'h0;
        tp_blue_d  = (video_on_d && |(bar_sel & BLUE_BARS))  ? 4'hF : 4'h0;
    end

    // Pattern registers, in step with pix_x.
    always_ff @(posedge clock_i) begin
        if (!res_i) begin
            tp_red_q   <= 4'h0;
            tp_green_q <= 4'h0;
            tp_blue_q  <= 4'h0;
        end else begin
            tp_red_q   <= tp_red_d;
            tp_green_q <= tp_green_d;
            tp_blue_q  <= tp_blue_d;
        end
    end

    assign vga_o.tp_red   = tp_red_q;
    assign vga_o.tp_green = tp_green_q;
    assign vga_o.tp_blue  = tp_blue_q;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: three generators (default 640x480 CLK_DIV=4, default
// geometry with CLK_DIV=1, and a tiny raster with CLK_DIV=3 and positive sync)
// driven with random reset pulses and checked edge by edge against an
// arithmetic raster model.
module tb_vga_timing_gen;

    localparam int N_CYC = 14000;

    // Per-instance configuration.
    localparam int DIV [3] = '{4, 1, 3};
    localparam int HA  [3] = '{640, 640, 16};
    localparam int HFP [3] = '{16, 16, 2};
    localparam int HS  [3] = '{96, 96, 3};
    localparam int HBP [3] = '{48, 48, 2};
    localparam int VA  [3] = '{480, 480, 8};
    localparam int VFP [3] = '{10, 10, 2};
    localparam int VS  [3] = '{2, 2, 2};
    localparam int VBP [3] = '{33, 33, 3};
    localparam int POL [3] = '{0, 0, 1};
    localparam int RUN_MIN [3] = '{3300, 900, 300};
    localparam int RUN_MAX [3] = '{5000, 2500, 2500};

    typedef struct packed {
        logic        tick;
        logic        hs;
        logic        vs;
        logic        von;
        logic [9:0]  x;
        logic [9:0]  y;
        logic        fs;
        logic [11:0] tp;
    } obs_t;

    logic       clk = 1'b0;
    logic [2:0] res = 3'b000;
    obs_t       got [3];
    obs_t       q [3][$];
    int         n_cmp = 0;
    int         n_bad = 0;

    always #5 clk = ~clk;

    vga_timing_gen_if vif0 ();
    vga_timing_gen_if vif1 ();
    vga_timing_gen_if vif2 ();

    vga_timing_gen #(
        .CLK_DIV(DIV[0]), .H_ACTIVE(HA[0]), .H_FP(HFP[0]), .H_SYNC(HS[0]), .H_BP(HBP[0]),
        .V_ACTIVE(VA[0]), .V_FP(VFP[0]), .V_SYNC(VS[0]), .V_BP(VBP[0]), .SYNC_POL(POL[0] != 0)
    ) u_dut0 (.clock_i(clk), .res_i(res[0]), .vga_o(vif0));

    vga_timing_gen #(
        .CLK_DIV(DIV[1]), .H_ACTIVE(HA[1]), .H_FP(HFP[1]), .H_SYNC(HS[1]), .H_BP(HBP[1]),
        .V_ACTIVE(VA[1]), .V_FP(VFP[1]), .V_SYNC(VS[1]), .V_BP(VBP[1]), .SYNC_POL(POL[1] != 0)
    ) u_dut1 (.clock_i(clk), .res_i(res[1]), .vga_o(vif1));

    vga_timing_gen #(
        .CLK_DIV(DIV[2]), .H_ACTIVE(HA[2]), .H_FP(HFP[2]), .H_SYNC(HS[2]), .H_BP(HBP[2]),
        .V_ACTIVE(VA[2]), .V_FP(VFP[2]), .V_SYNC(VS[2]), .V_BP(VBP[2]), .SYNC_POL(POL[2] != 0)
    ) u_dut2 (.clock_i(clk), .res_i(res[2]), .vga_o(vif2));

`ifdef VGA_TEST_PATTERN_EN
    assign got[0] = {vif0.pix_tick, vif0.hsync, vif0.vsync, vif0.video_on, vif0.pix_x, vif0.pix_y,
                     vif0.frame_start, vif0.tp_red, vif0.tp_green, vif0.tp_blue};
    assign got[1] = {vif1.pix_tick, vif1.hsync, vif1.vsync, vif1.video_on, vif1.pix_x, vif1.pix_y,
                     vif1.frame_start, vif1.tp_red, vif1.tp_green, vif1.tp_blue};
    assign got[2] = {vif2.pix_tick, vif2.hsync, vif2.vsync, vif2.video_on, vif2.pix_x, vif2.pix_y,
                     vif2.frame_start, vif2.tp_red, vif2.tp_green, vif2.tp_blue};

    // Bar colours left to right: white, yellow, cyan, green, magenta, red, blue, black.
    function automatic logic [11:0] bar_colour(input int bar);
        case (bar)
            0: return 12'hFFF;
            1: return 12'hFF0;
            2: return 12'h0FF;
            3: return 12'h0F0;
            4: return 12'hF0F;
            5: return 12'hF00;
            6: return 12'h00F;
            default: return 12'h000;
        endcase
    endfunction
`else
    assign got[0] = {vif0.pix_tick, vif0.hsync, vif0.vsync, vif0.video_on, vif0.pix_x, vif0.pix_y,
                     vif0.frame_start, 12'h000};
    assign got[1] = {vif1.pix_tick, vif1.hsync, vif1.vsync, vif1.video_on, vif1.pix_x, vif1.pix_y,
                     vif1.frame_start, 12'h000};
    assign got[2] = {vif2.pix_tick, vif2.hsync, vif2.vsync, vif2.video_on, vif2.pix_x, vif2.pix_y,
                     vif2.frame_start, 12'h000};
`endif

    // Expected outputs after one rising edge. t counts edges since reset
    // release (t=0 is the first released edge); the raster position is
    // simply elapsed pixels modulo line and frame length.
    function automatic obs_t model(input int d, input bit in_rst, input longint t);
        obs_t    o;
        bit      pol;
        longint  p;
        int      ht, vt, x, y;
        pol = (POL[d] != 0);
        o   = '0;
        if (in_rst) begin
            o.hs = ~pol;
            o.vs = ~pol;
            return o;
        end
        ht    = HA[d] + HFP[d] + HS[d] + HBP[d];
        vt    = VA[d] + VFP[d] + VS[d] + VBP[d];
        p     = t / DIV[d];
        x     = int'(p % ht);
        y     = int'((p / ht) % vt);
        o.x   = 10'(x);
        o.y   = 10'(y);
        o.tick = (t > 0) && ((t % DIV[d]) == 0);
        o.von = (x < HA[d]) && (y < VA[d]);
        o.hs  = ((x >= HA[d] + HFP[d]) && (x < HA[d] + HFP[d] + HS[d])) ? pol : ~pol;
        o.vs  = ((y >= VA[d] + VFP[d]) && (y < VA[d] + VFP[d] + VS[d])) ? pol : ~pol;
        o.fs  = (t % (longint'(DIV[d]) * ht * vt)) == 0;
`ifdef VGA_TEST_PATTERN_EN
        if (o.von) o.tp = bar_colour(x / (HA[d] / 8));
`endif
        return o;
    endfunction

    // Stimulus: random reset pulses and run lengths; pushes the expected
    // response for each upcoming edge.
    initial begin
        int rst_left [3];
        int run_left [3];
        longint t_next [3];
        for (int d = 0; d < 3; d++) begin
            rst_left[d] = 3;
            run_left[d] = 0;
            t_next[d]   = 0;
        end
        for (int c = 0; c < N_CYC; c++) begin
            @(negedge clk);
            for (int d = 0; d < 3; d++) begin
                if (rst_left[d] > 0) begin
                    res[d] = 1'b0;
                    q[d].push_back(model(d, 1'b1, 0));
                    t_next[d] = 0;
                    rst_left[d]--;
                    if (rst_left[d] == 0) begin
                        run_left[d] = $urandom_range(RUN_MAX[d], RUN_MIN[d]);
                        $display("dut%0d @%0t: release reset, run %0d clocks", d, $time, run_left[d]);
                    end
                end else begin
                    res[d] = 1'b1;
                    q[d].push_back(model(d, 1'b0, t_next[d]));
                    t_next[d]++;
                    run_left[d]--;
                    if (run_left[d] == 0) begin
                        rst_left[d] = $urandom_range(4, 1);
                        $display("dut%0d @%0t: reset for %0d clocks at edge %0d", d, $time, rst_left[d], t_next[d]);
                    end
                end
            end
        end
        @(negedge clk);
        @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            n_cmp++;
            if (q[d].size() != 0) begin
                n_bad++;
                $display("FAIL dut%0d drain: %0d expected responses left, required 0", d, q[d].size());
            end
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    // Monitor: every edge each generator presents a new raster state.
    always @(posedge clk) begin
        obs_t want;
        #1;
        for (int d = 0; d < 3; d++) begin
            if (q[d].size() > 0) begin
                want = q[d].pop_front();
                n_cmp++;
                if (got[d] !== want) begin
                    n_bad++;
                    if (n_bad <= 20)
                        $display("FAIL dut%0d raster @%0t: got tick=%b hs=%b vs=%b von=%b x=%0d y=%0d fs=%b tp=%h, required tick=%b hs=%b vs=%b von=%b x=%0d y=%0d fs=%b tp=%h",
                                 d, $time, got[d].tick, got[d].hs, got[d].vs, got[d].von, got[d].x, got[d].y,
                                 got[d].fs, got[d].tp, want.tick, want.hs, want.vs, want.von, want.x, want.y,
                                 want.fs, want.tp);
                end
            end
        end
    end

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Generates VGA 640x480@60 raster timing from the system clock.
- Produces hsync/vsync, the active-video flag and the current pixel coordinates.
- Sits directly upstream of the colour stage, which uses video_on and pix_x/pix_y to drive red/green/blue.
- Derives the pixel rate with an internal clock-enable divider, so the design stays in one clock domain.

Parameters:
- CLK_DIV, 4: system clocks per pixel (100 MHz / 4 = 25 MHz); must be >= 1.
- H_ACTIVE, 640: visible pixels per line.
- H_FP, 16: horizontal front porch, in pixels.
- H_SYNC, 96: horizontal sync width, in pixels.
- H_BP, 48: horizontal back porch, in pixels.
- V_ACTIVE, 480: visible lines per frame.
- V_FP, 10: vertical front porch, in lines.
- V_SYNC, 2: vertical sync width, in lines.
- V_BP, 33: vertical back porch, in lines.
- SYNC_POL, 0: sync polarity during the pulse (0 = active-low).

Ports:
- clock  in  1  system clock; all logic on the rising edge.
- res  in  1  reset, synchronous, active-low.
- pix_tick  out  1  one-clock pulse marking each pixel period.
- hsync  out  1  horizontal sync.
- vsync  out  1  vertical sync.
- video_on  out  1  high while the pixel is inside the active area.
- pix_x  out  10  current column.
- pix_y  out  10  current row.
- frame_start  out  1  one-clock pulse at the start of pixel (0,0) of each frame.

Behaviour:
- Derived totals: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800); V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (525). Both must be <= 1024.
- All counters are 10 bits, except div_cnt, which is ceil(log2(CLK_DIV)) bits with a minimum of 1.
- Reset: while res=0 at a rising edge, the following are cleared:
  - div_cnt, h_cnt and v_cnt to 0.
  - pix_x and pix_y to 0.
  - video_on, pix_tick and frame_start to 0.
  - hsync and vsync to ~SYNC_POL, i.e. inactive.
- Reset has priority over all other logic, including mid-line and mid-frame. There is no partial-frame recovery: a restart always begins at (0,0).
- Divider:
  - div_cnt counts 0..CLK_DIV-1 and wraps to 0.
  - The internal tick is asserted when div_cnt == CLK_DIV-1.
  - With CLK_DIV=1 the tick is asserted on every clock.
- Horizontal counter: on a tick, h_cnt increments; h_cnt == H_TOTAL-1 wraps to 0.
- Vertical counter:
  - v_cnt increments only on a tick where h_cnt wraps.
  - v_cnt == V_TOTAL-1 at that point wraps to 0.
- Output registering:
  - All outputs are registered and computed from the next-state values of the counters, so they always agree with h_cnt/v_cnt.
  - There is no skew between pix_x/pix_y and the sync/video flags.
- pix_x = h_cnt; pix_y = v_cnt. Both are reported in blanking as well, and the consumer must gate with video_on.
- video_on = (h_cnt < H_ACTIVE) && (v_cnt < V_ACTIVE).
- hsync = SYNC_POL while H_ACTIVE+H_FP <= h_cnt <= H_ACTIVE+H_FP+H_SYNC-1 (656..751); otherwise ~SYNC_POL.
- vsync = SYNC_POL while V_ACTIVE+V_FP <= v_cnt <= V_ACTIVE+V_FP+V_SYNC-1 (490..491); otherwise ~SYNC_POL.
- vsync is line-aligned: it changes only at the h_cnt wrap.
- pix_tick: registered copy of the internal tick, one clock wide.
- frame_start:
  - Pulses for one clock on the edge where h_cnt and v_cnt both wrap to 0.
  - Also pulses on the first edge after reset release.
- First edge after reset release:
  - video_on=1, pix_x=0, pix_y=0, frame_start=1.
  - The first pixel (0,0) therefore lasts CLK_DIV clocks from that edge.
- Sync on the wrap pixel: a line and a frame wrap on the same tick produce one consistent update; no sync glitch is permitted.

Optional Feature:
- Macro: VGA_TEST_PATTERN_EN.
- When defined, three extra outputs are added:
  - tp_red  out 4
  - tp_green  out 4
  - tp_blue  out 4
- The extra outputs are registered in step with pix_x.
- The pattern is 8 vertical bars of H_ACTIVE/8 pixels (80 each), selected by comparing pix_x to multiples of H_ACTIVE/8.
- Bar colours, left to right: white, yellow, cyan, green, magenta, red, blue, black (each channel 4'hF or 4'h0).
- All channels are 0 when video_on=0 and during reset.
- When undefined, the ports and the pattern logic are absent.

Test Plan:
- Reset, then release with CLK_DIV=4 → first edge gives video_on=1, pix_x=0, pix_y=0, frame_start=1, hsync=vsync=1; pix_tick then pulses every 4 clocks.
- Run one line → pix_x steps 0..799 then wraps and pix_y becomes 1; hsync is low for exactly 96 ticks (384 clocks) starting at pix_x=656; video_on is high for pix_x 0..639.
- Run a full frame → vsync is low for exactly 2 lines (pix_y 490..491, 6400 clocks); frame_start repeats every 1,680,000 clocks; video_on is never high with pix_y >= 480.
- Assert res=0 mid-frame (pix_x=300, pix_y=200) for 3 clocks → outputs show reset values on the first reset edge; after release, timing restarts at (0,0) with frame_start=1.
- Use CLK_DIV=1 → pix_tick stays high continuously and pix_x advances every clock; line period is 800 clocks.
- With VGA_TEST_PATTERN_EN defined → pix_x=0: tp = F,F,F; pix_x=80: F,F,0; pix_x=560: 0,0,0; pix_x=700: 0,0,0 (blanking).
